// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, LSB first, idle-high line.
// The line is double-flopped before use. A start bit is confirmed at mid-bit.
// Each data bit is sampled one bit period after the previous sample.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
// When that macro is absent the frame is 8N1 and parity_err is tied low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = 217
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = ($clog2(CLKS_PER_BIT) > 9) ? $clog2(CLKS_PER_BIT) : 9;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  logic          rx_m, rx_s;
  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    index_reg, index_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_next;
  logic          valid_next, ferr_next;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_PARITY_EN
  // A parity miss in this frame suppresses both rx_valid and frame_err at the stop bit.
  logic perr_flag_reg, perr_flag_next;
  logic perr_next;

  // Parity error pulse and per-frame parity-miss flag.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      parity_err    <= 1'b0;
      perr_flag_reg <= 1'b0;
    end else begin
      parity_err    <= perr_next;
      perr_flag_reg <= perr_flag_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      index_reg <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      index_reg <= index_next;
      shift_reg <= shift_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      frame_err <= ferr_next;
    end
  end

  // Next-state logic; every transition restarts the cycle counter.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg + CW'(1);
    index_next = index_reg;
    shift_next = shift_reg;
    data_next  = rx_data;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next      = 1'b0;
    perr_flag_next = perr_flag_reg;
`endif
    case (state_reg)
      IDLE: begin
        count_next = '0;
`ifdef UART_RX_PARITY_EN
        perr_flag_next = 1'b0;
`endif
        if (!rx_s) state_next = START;
      end
      START: begin
        if (count_reg == HALF_LAST) begin
          count_next = '0;
          index_next = 3'd0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (count_reg == BIT_LAST) begin
          count_next            = '0;
          shift_next[index_reg] = rx_s;
          index_next            = index_reg + 3'd1;
          if (index_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (count_reg == BIT_LAST) begin
          count_next = '0;
          state_next = STOP;
          if (rx_s != (^shift_reg)) begin
            perr_next      = 1'b1;
            perr_flag_next = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (count_reg == BIT_LAST) begin
          count_next = '0;
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!perr_flag_reg) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
`else
            data_next  = shift_reg;
            valid_next = 1'b1;
`endif
          end else begin
            state_next = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            ferr_next = !perr_flag_reg;
`else
            ferr_next = 1'b1;
`endif
          end
        end
      end
      WAIT_HIGH: begin
        count_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level event model of uart_rx.
// Define UART_RX_PARITY_EN to exercise the even-parity build.
module tb_uart_rx;

  localparam int CLKS = 434;
  localparam int HALF = 217;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_rx #(.CLKS_PER_BIT(CLKS), .HALF_BIT(HALF)) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #10 clk_50M = ~clk_50M;

  int unsigned cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  // Expected output event: kind 0 = rx_valid, 1 = frame_err, 2 = parity_err.
  // nom is the cycle of the nominal mid-sample of the deciding bit on the rx pin.
  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned nom;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] got[$];
  logic [7:0] model_byte = 8'h00;
  int         checks = 0, passes = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  // Compare process: every pulse must match the next expected event in kind,
  // data and timing; rx_data must always hold the last good byte.
  initial begin
    int  npulse;
    int  kind;
    ev_t e;
    forever begin
      @(negedge clk_50M);
      #1;
      if (mon_en) begin
        npulse = $countones({rx_valid, frame_err, parity_err});
        if (npulse != 0) begin
          check("one_pulse_at_a_time", npulse, 1);
          kind = rx_valid ? 0 : (frame_err ? 1 : 2);
          if (rx_valid) begin n_valid++; got.push_back(rx_data); end
          if (frame_err) n_ferr++;
          if (parity_err) n_perr++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pulse: got kind %0d, required no pulse (cycle %0d)", kind, cyc);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_latency_in_window", (cyc >= e.nom) && (cyc <= e.nom + 3), 1);
            if (e.kind == 0) model_byte = e.data;
          end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].nom + 3) begin
          e = exp_q.pop_front();
          checks++;
          $display("FAIL missed_pulse: got none, required kind %0d by cycle %0d", e.kind, e.nom + 3);
        end
        check("rx_data_hold", rx_data, model_byte);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CLKS) @(negedge clk_50M);
  endtask

  // Drive one frame from a negedge; stop_low > 0 holds the stop bit low that long.
  task automatic send_frame(input logic [7:0] b, input bit par_good, input int stop_low);
    int unsigned c;
    ev_t e;
    c      = cyc;
    e.data = b;
    if (!par_good) begin
      e.kind = 2; e.nom = c + 9 * CLKS + HALF; exp_q.push_back(e);
    end else if (stop_low == 0) begin
      e.kind = 0; e.nom = c + (9 + PB) * CLKS + HALF; exp_q.push_back(e);
    end else begin
      e.kind = 1; e.nom = c + (9 + PB) * CLKS + HALF; exp_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_good ? (^b) : ~(^b));
`endif
    if (stop_low == 0) drive_bit(1'b1);
    else begin
      rx = 1'b0;
      repeat (stop_low) @(negedge clk_50M);
      rx = 1'b1;
    end
  endtask

  // Stimulus sequence with literal expectations.
  initial begin
    @(negedge clk_50M);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk_50M);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);
    mon_en = 1'b1;

    // Single 0x53 frame.
    send_frame(8'h53, 1'b1, 0);
    repeat (20) @(negedge clk_50M);
    check("s_busy_low_after_stop", busy, 0);
    check("s_valid_count", n_valid, 1);
    check("s_data", got_at(0), 8'h53);
    check("s_rx_data", rx_data, 8'h53);
    check("s_no_frame_err", n_ferr, 0);

    // Back-to-back frames with no idle time.
    send_frame(8'h4D, 1'b1, 0);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'h32, 1'b1, 0);
    repeat (20) @(negedge clk_50M);
    check("b2b_valid_count", n_valid, 4);
    check("b2b_data0", got_at(1), 8'h4D);
    check("b2b_data1", got_at(2), 8'h00);
    check("b2b_data2", got_at(3), 8'h32);

    // 100-cycle glitch on an idle line.
    rx = 1'b0;
    repeat (100) @(negedge clk_50M);
    check("glitch_busy_during", busy, 1);
    rx = 1'b1;
    repeat (300) @(negedge clk_50M);
    check("glitch_busy_after", busy, 0);
    check("glitch_valid_count", n_valid, 4);
    check("glitch_ferr_count", n_ferr, 0);
    check("glitch_rx_data", rx_data, 8'h32);

    // 0xA5 with stop bit held low (break).
    send_frame(8'hA5, 1'b1, 2000);
    repeat (5) @(negedge clk_50M);
    check("break_ferr_count", n_ferr, 1);
    check("break_valid_count", n_valid, 4);
    check("break_rx_data", rx_data, 8'h32);
    check("break_busy_after_high", busy, 0);

    // Reset during data bit 4 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (HALF) @(negedge clk_50M);
    rst_n      = 1'b0;
    model_byte = 8'h00;
    repeat (3) @(negedge clk_50M);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (5 * CLKS) @(negedge clk_50M);
    check("midrst_idle_after_release", busy, 0);
    check("midrst_no_valid", n_valid, 4);
    send_frame(8'h12, 1'b1, 0);
    repeat (20) @(negedge clk_50M);
    check("after_rst_valid_count", n_valid, 5);
    check("after_rst_data", got_at(4), 8'h12);

`ifdef UART_RX_PARITY_EN
    // 0x07 with wrong then correct even parity.
    send_frame(8'h07, 1'b0, 0);
    repeat (20) @(negedge clk_50M);
    check("par_bad_perr_count", n_perr, 1);
    check("par_bad_no_valid", n_valid, 5);
    check("par_bad_rx_data", rx_data, 8'h12);
    send_frame(8'h07, 1'b1, 0);
    repeat (20) @(negedge clk_50M);
    check("par_good_valid_count", n_valid, 6);
    check("par_good_data", got_at(5), 8'h07);
    check("par_good_perr_count", n_perr, 1);
`else
    check("no_parity_perr_count", n_perr, 0);
`endif

    repeat (10) @(negedge clk_50M);
    check("no_pending_events", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #4000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_50M cycles per bit (115200 baud at 50 MHz).
REQ-002 The module SHALL have parameter HALF_BIT, default 217, meaning the cycles from the detected start edge to the start-bit mid-sample.
REQ-003 The module SHALL have port clk_50M  input  1  system clock, 50 MHz; the block uses one clock only.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first.
REQ-006 The module SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 The module SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 The module SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 The module SHALL have port parity_err  output  1  one-cycle pulse when the parity bit mismatches.
REQ-010 The module SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH, with one cycle counter (width >= 9 bits) and one 3-bit bit index.
REQ-013 IDLE SHALL go to START with counter=0 on the first cycle rx_s==0.
REQ-014 In START, when counter==HALF_BIT-1: if rx_s==0, the FSM SHALL go to DATA with counter=0 and index=0; otherwise it SHALL go to IDLE as a glitch, with no output pulse.
REQ-015 In DATA, when counter==CLKS_PER_BIT-1, the FSM SHALL shift rx_s into shift-register bit [index] and clear counter; after index 7 it SHALL go to PARITY if configured, else to STOP.
REQ-016 In STOP, when counter==CLKS_PER_BIT-1: if rx_s==1, the FSM SHALL load rx_data and pulse rx_valid in the following cycle, then go to IDLE.
REQ-017 In STOP, when counter==CLKS_PER_BIT-1: if rx_s==0, the FSM SHALL pulse frame_err, leave rx_data unchanged, and go to WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL go to IDLE on the first cycle rx_s==1, so a break condition does not produce repeated frames.
REQ-019 rx_valid, frame_err and parity_err SHALL each be high for exactly one clk_50M cycle per event and never simultaneously.
REQ-020 Latency SHALL be: rx_valid asserts at most 3 cycles after the nominal stop-bit mid-sample on the rx pin, counting the synchronizer.
REQ-021 Back-to-back frames with zero idle time SHALL be received without loss, since IDLE accepts a start edge in the cycle after STOP completes.
REQ-022 The counter SHALL never exceed CLKS_PER_BIT-1; every state transition SHALL clear it.

Reset
REQ-023 When rst_n is low, the module SHALL asynchronously force state=IDLE, counter=0, index=0, shift register=0, rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0 and busy=0.
REQ-024 When rst_n is low, both synchronizer flops SHALL be forced to 1, which is the line-idle value.
REQ-025 If reset asserts mid-frame, the partial byte SHALL be discarded; after release, the module SHALL wait in IDLE for a fresh falling edge and SHALL NOT resynchronize on the remaining bits of the interrupted frame as a start edge unless rx_s==0.

Configuration
REQ-026 The macro UART_RX_PARITY_EN SHALL control parity handling.
REQ-027 When UART_RX_PARITY_EN is defined, an even-parity bit SHALL follow data bit 7 and the PARITY state SHALL exist.
REQ-028 In PARITY, at counter==CLKS_PER_BIT-1, the module SHALL compare rx_s with the XOR of the 8 data bits.
REQ-029 On a parity mismatch, the module SHALL pulse parity_err, leave rx_data unchanged, and still go to STOP with no frame_err pulse for that frame even if the stop bit is low.
REQ-030 When UART_RX_PARITY_EN is not defined, the PARITY state SHALL be absent, the frame SHALL be 8N1, and parity_err SHALL be tied to 0.

Verification
REQ-031 The bench SHALL drive 8N1 byte 0x53 ('S') at 434 clocks/bit, expecting rx_valid once, rx_data=0x53, frame_err=0, and busy low after the stop bit.
REQ-032 The bench SHALL drive bytes 0x4D, 0x00, 0x32 back-to-back with no idle time, expecting three rx_valid pulses carrying 0x4D, 0x00 and 0x32 in order.
REQ-033 The bench SHALL drive a 100-cycle low glitch on an idle line, expecting a return to IDLE with no rx_valid or frame_err pulse and rx_data unchanged.
REQ-034 The bench SHALL drive byte 0xA5 with the stop bit held low for 2000 cycles, expecting one frame_err pulse, rx_data unchanged, and no further pulses until the line returns high.
REQ-035 The bench SHALL assert rst_n low during data bit 4 of 0xFF and then release it with the line high, expecting all outputs at reset values and a subsequent 0x12 frame received correctly.
REQ-036 With UART_RX_PARITY_EN defined, the bench SHALL drive 0x07 with parity bit 0, expecting a parity_err pulse and no rx_valid, and then 0x07 with parity bit 1, expecting rx_valid with rx_data=0x07.
